// File: rtl/prog_loader.sv
// prog_loader: length-prefixed byte stream to 16-bit instruction memory writer.
// Holds the CPU in reset until every word of the program has been written.
module prog_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    LEN_HI, LEN_LO, W_HI, W_LO, WRITE, DONE, ERR
  } state_t;

  // Capacity in words; N equal to this is still a legal load.
  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  state_t              state_q;
  logic [15:0]         cnt_q;
  logic [ADDR_W:0]     idx_q;
  logic [7:0]          whi_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [15:0]         wdata_q;
  logic                cpu_rst_q;
  logic                done_q;
  logic                err_q;

  logic                accept;
  logic [15:0]         n_d;
  logic                last_d;

  // Byte acceptance is a pure decode of the current state.
  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      LEN_HI, LEN_LO, W_HI, W_LO: in_ready = 1'b1;
      default:                    in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid && in_ready;
  assign n_d    = {cnt_q[15:8], in_data};
  assign last_d = (17'(idx_q) + 17'd1) == {1'b0, cnt_q};

  // Loader FSM with registered memory-write and CPU-control outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= LEN_HI;
      cnt_q     <= '0;
      idx_q     <= '0;
      whi_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      we_q <= 1'b0;
      unique case (state_q)
        LEN_HI: begin
          if (accept) begin
            cnt_q[15:8] <= in_data;
            state_q     <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (accept) begin
            cnt_q <= n_d;
            idx_q <= '0;
            if (n_d == 16'd0) begin
              cpu_rst_q <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= DONE;
            end else if ({1'b0, n_d} > CAP) begin
              err_q   <= 1'b1;
              state_q <= ERR;
            end else begin
              state_q <= W_HI;
            end
          end
        end
        W_HI: begin
          if (accept) begin
            whi_q   <= in_data;
            state_q <= W_LO;
          end
        end
        W_LO: begin
          if (accept) begin
            we_q    <= 1'b1;
            addr_q  <= idx_q[ADDR_W-1:0];
            wdata_q <= {whi_q, in_data};
            state_q <= WRITE;
          end
        end
        WRITE: begin
          if (last_d) begin
            cpu_rst_q <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= W_HI;
          end
        end
        DONE: begin
          if (reload) begin
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            state_q   <= LEN_HI;
          end
        end
        ERR: begin
          state_q <= ERR;
        end
        default: begin
          state_q <= LEN_HI;
        end
      endcase
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: scoreboard bench for prog_loader with a 16-word memory.
// Expected writes are queued as bytes are driven and popped by a write monitor.
module tb_prog_loader;

  localparam int AW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          reload = 1'b0;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_wdata;
  logic          cpu_rst;
  logic          done;
  logic          err;

  prog_loader #(.ADDR_W(AW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .reload    (reload),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_rst   (cpu_rst),
    .done      (done),
    .err       (err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;
  int wr_count = 0;
  int wr_cyc[$];
  logic [AW-1:0] exp_addr[$];
  logic [15:0]   exp_data[$];
  logic prev_we = 1'b0;

  // Write monitor: every imem_we pulse is checked against the scoreboard.
  always @(negedge CLK) begin
    logic [AW-1:0] ea;
    logic [15:0]   ed;
    if (RST) begin
      prev_we = 1'b0;
    end else begin
      if (imem_we) begin
        wr_count++;
        wr_cyc.push_back(cyc);
        compared++;
        if (prev_we !== 1'b0) begin
          mismatched++;
          $display("FAIL we_consecutive: imem_we high two cycles, required single-cycle pulse");
        end
        compared++;
        if (exp_addr.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_write: addr=%0h data=%h, required no write", imem_addr, imem_wdata);
        end else begin
          ea = exp_addr.pop_front();
          ed = exp_data.pop_front();
          if (imem_addr !== ea || imem_wdata !== ed) begin
            mismatched++;
            $display("FAIL write: got addr=%0h data=%h, required addr=%0h data=%h",
                     imem_addr, imem_wdata, ea, ed);
          end
        end
      end
      prev_we = imem_we;
    end
  end

  task automatic push_exp(input logic [AW-1:0] a, input logic [15:0] d);
    exp_addr.push_back(a);
    exp_data.push_back(d);
  endtask

  // Offers one byte and returns the cycle of the accepting edge (-1 on timeout).
  task automatic send_byte(input logic [7:0] b, output int acc);
    acc = -1;
    in_valid = 1'b1;
    in_data = b;
    for (int k = 0; k < 50; k++) begin
      if (in_ready) begin
        @(posedge CLK);
        #1;
        acc = cyc;
        break;
      end
      @(posedge CLK);
      #1;
    end
    in_valid = 1'b0;
    compared++;
    if (acc < 0) begin
      mismatched++;
      $display("FAIL byte_timeout: byte %h not accepted within 50 cycles", b);
    end
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int k = 0; k < 200; k++) begin
      if (done) begin
        dc = cyc;
        break;
      end
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic apply_reset();
    in_valid = 1'b0;
    reload = 1'b0;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    exp_addr.delete();
    exp_data.delete();
  endtask

  task automatic test_reset();
    #2;
    RST = 1'b1;
    #1;
    compared++;
    if ({in_ready, cpu_rst, done, err, imem_we} !== 5'b11000 ||
        imem_addr !== '0 || imem_wdata !== 16'h0) begin
      mismatched++;
      $display("FAIL reset_values: rdy=%b crst=%b done=%b err=%b we=%b addr=%0h data=%h, required 1 1 0 0 0 0 0000",
               in_ready, cpu_rst, done, err, imem_we, imem_addr, imem_wdata);
    end
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic test_single();
    int a;
    int w0;
    w0 = wr_count;
    push_exp(4'h0, 16'hABCD);
    send_byte(8'h00, a);
    send_byte(8'h01, a);
    send_byte(8'hAB, a);
    send_byte(8'hCD, a);
    for (int k = 0; k < 20; k++) begin
      if (done || !cpu_rst) break;
      @(posedge CLK);
      #1;
    end
    compared++;
    if (done !== 1'b1 || cpu_rst !== 1'b0) begin
      mismatched++;
      $display("FAIL single_release: done=%b cpu_rst=%b, required 1 0 on same edge", done, cpu_rst);
    end
    compared++;
    if (in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL single_ready: in_ready=%b, required 0", in_ready);
    end
    compared++;
    if (wr_count - w0 != 1 || exp_addr.size() != 0) begin
      mismatched++;
      $display("FAIL single_writes: writes=%0d pending=%0d, required 1 0", wr_count - w0, exp_addr.size());
    end
  endtask

  task automatic test_back_to_back();
    int a;
    int t1;
    int dc;
    int base;
    apply_reset();
    base = wr_cyc.size();
    push_exp(4'h0, 16'h1234);
    push_exp(4'h1, 16'h5678);
    push_exp(4'h2, 16'h9ABC);
    send_byte(8'h00, a);
    send_byte(8'h03, a);
    send_byte(8'h12, t1);
    send_byte(8'h34, a);
    send_byte(8'h56, a);
    send_byte(8'h78, a);
    send_byte(8'h9A, a);
    send_byte(8'hBC, a);
    wait_done(dc);
    compared++;
    if (wr_cyc.size() - base != 3) begin
      mismatched++;
      $display("FAIL b2b_count: writes=%0d, required 3", wr_cyc.size() - base);
    end else begin
      compared++;
      if (wr_cyc[base] - t1 != 1 || wr_cyc[base+1] - wr_cyc[base] != 3 ||
          wr_cyc[base+2] - wr_cyc[base+1] != 3) begin
        mismatched++;
        $display("FAIL b2b_spacing: offsets %0d %0d %0d, required 1 3 3",
                 wr_cyc[base] - t1, wr_cyc[base+1] - wr_cyc[base], wr_cyc[base+2] - wr_cyc[base+1]);
      end
    end
    // done rises on the 9th edge counting the edge that took the first word byte.
    compared++;
    if (dc < 0 || dc - t1 != 8) begin
      mismatched++;
      $display("FAIL b2b_done_time: done at +%0d, required +8", dc - t1);
    end
  endtask

  task automatic test_zero();
    int a;
    int w0;
    apply_reset();
    w0 = wr_count;
    send_byte(8'h00, a);
    compared++;
    if (done !== 1'b0) begin
      mismatched++;
      $display("FAIL zero_early: done=%b after one header byte, required 0", done);
    end
    send_byte(8'h00, a);
    compared++;
    if (done !== 1'b1 || cpu_rst !== 1'b0) begin
      mismatched++;
      $display("FAIL zero_done: done=%b cpu_rst=%b, required 1 0", done, cpu_rst);
    end
    repeat (5) @(posedge CLK);
    #1;
    compared++;
    if (wr_count != w0) begin
      mismatched++;
      $display("FAIL zero_nowrite: writes=%0d, required 0", wr_count - w0);
    end
  endtask

  task automatic test_err_and_full();
    int a;
    int dc;
    int w0;
    apply_reset();
    w0 = wr_count;
    send_byte(8'h00, a);
    send_byte(8'h11, a);
    compared++;
    if (err !== 1'b1 || in_ready !== 1'b0 || cpu_rst !== 1'b1 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL err_enter: err=%b rdy=%b crst=%b done=%b, required 1 0 1 0", err, in_ready, cpu_rst, done);
    end
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_data = 8'(k * 37);
      @(posedge CLK);
      #1;
    end
    in_valid = 1'b0;
    compared++;
    if (err !== 1'b1 || in_ready !== 1'b0 || cpu_rst !== 1'b1 || wr_count != w0) begin
      mismatched++;
      $display("FAIL err_sticky: err=%b rdy=%b crst=%b writes=%0d, required 1 0 1 0",
               err, in_ready, cpu_rst, wr_count - w0);
    end
    apply_reset();
    compared++;
    if (err !== 1'b0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL err_clear: err=%b rdy=%b, required 0 1", err, in_ready);
    end
    w0 = wr_count;
    send_byte(8'h00, a);
    send_byte(8'h10, a);
    for (int i = 0; i < 16; i++) begin
      logic [15:0] w;
      w = 16'hA000 + 16'(i * 16'h0111);
      push_exp(4'(i), w);
      send_byte(w[15:8], a);
      send_byte(w[7:0], a);
    end
    wait_done(dc);
    compared++;
    if (dc < 0 || err !== 1'b0 || cpu_rst !== 1'b0) begin
      mismatched++;
      $display("FAIL full_done: done=%b err=%b crst=%b, required 1 0 0", done, err, cpu_rst);
    end
    compared++;
    if (wr_count - w0 != 16 || exp_addr.size() != 0) begin
      mismatched++;
      $display("FAIL full_writes: writes=%0d pending=%0d, required 16 0", wr_count - w0, exp_addr.size());
    end
  endtask

  task automatic test_reload();
    int a;
    int dc;
    reload = 1'b1;
    @(posedge CLK);
    #1;
    reload = 1'b0;
    compared++;
    if (cpu_rst !== 1'b1 || done !== 1'b0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reload_edge: crst=%b done=%b rdy=%b, required 1 0 1", cpu_rst, done, in_ready);
    end
    push_exp(4'h0, 16'hFFFF);
    send_byte(8'h00, a);
    send_byte(8'h01, a);
    send_byte(8'hFF, a);
    send_byte(8'hFF, a);
    wait_done(dc);
    compared++;
    if (dc < 0 || cpu_rst !== 1'b0 || exp_addr.size() != 0) begin
      mismatched++;
      $display("FAIL reload_load: done=%b crst=%b pending=%0d, required 1 0 0", done, cpu_rst, exp_addr.size());
    end
    reload = 1'b1;
    @(posedge CLK);
    #1;
    reload = 1'b0;
    push_exp(4'h0, 16'h1111);
    push_exp(4'h1, 16'h2222);
    send_byte(8'h00, a);
    send_byte(8'h02, a);
    send_byte(8'h11, a);
    reload = 1'b1;
    @(posedge CLK);
    #1;
    reload = 1'b0;
    compared++;
    if (in_ready !== 1'b1 || done !== 1'b0 || cpu_rst !== 1'b1) begin
      mismatched++;
      $display("FAIL reload_ignored: rdy=%b done=%b crst=%b, required 1 0 1", in_ready, done, cpu_rst);
    end
    send_byte(8'h11, a);
    send_byte(8'h22, a);
    send_byte(8'h22, a);
    wait_done(dc);
    compared++;
    if (dc < 0 || exp_addr.size() != 0) begin
      mismatched++;
      $display("FAIL reload_wlo_load: done=%b pending=%0d, required 1 0", done, exp_addr.size());
    end
  endtask

  task automatic test_midload_rst();
    int a;
    int dc;
    apply_reset();
    push_exp(4'h0, 16'h0101);
    push_exp(4'h1, 16'h0202);
    send_byte(8'h00, a);
    send_byte(8'h04, a);
    send_byte(8'h01, a);
    send_byte(8'h01, a);
    send_byte(8'h02, a);
    send_byte(8'h02, a);
    send_byte(8'h03, a);
    RST = 1'b1;
    #1;
    compared++;
    if ({in_ready, cpu_rst, done, err, imem_we} !== 5'b11000 ||
        imem_addr !== '0 || imem_wdata !== 16'h0) begin
      mismatched++;
      $display("FAIL midload_async: rdy=%b crst=%b done=%b err=%b we=%b addr=%0h data=%h, required 1 1 0 0 0 0 0000",
               in_ready, cpu_rst, done, err, imem_we, imem_addr, imem_wdata);
    end
    compared++;
    if (exp_addr.size() != 0) begin
      mismatched++;
      $display("FAIL midload_prior: pending=%0d, required 0", exp_addr.size());
    end
    @(posedge CLK);
    #1;
    RST = 1'b0;
    push_exp(4'h0, 16'h0007);
    send_byte(8'h00, a);
    send_byte(8'h01, a);
    send_byte(8'h00, a);
    send_byte(8'h07, a);
    wait_done(dc);
    compared++;
    if (dc < 0 || cpu_rst !== 1'b0 || exp_addr.size() != 0) begin
      mismatched++;
      $display("FAIL midload_reload: done=%b crst=%b pending=%0d, required 1 0 0", done, cpu_rst, exp_addr.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_zero();
    test_err_and_full();
    test_reload();
    test_midload_rst();
    repeat (3) @(posedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader for the little-computer CPU. It receives a length-prefixed program over an 8-bit valid/ready stream and assembles 16-bit instruction words. It writes them sequentially into CPU instruction memory from address 0, holding the CPU in reset until the load completes. It is the hardware counterpart of the bench-side instruction load: the writer that fills instruction memory before the CPU starts fetching.

## Interface
- ADDR_W, 8, instruction memory address width; capacity 2**ADDR_W words
- CLK  in  1  system clock, rising-edge active
- RST  in  1  reset, asynchronous, active-high
- in_valid  in  1  byte-stream valid
- in_data  in  8  byte-stream data
- in_ready  out  1  loader can accept a byte this cycle
- reload  in  1  one-cycle pulse; restarts loading from DONE
- imem_we  out  1  instruction memory write strobe, one cycle per word
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  16  instruction word
- cpu_rst  out  1  holds CPU in reset (active-high) while loading
- done  out  1  program loaded, CPU released
- err  out  1  header length exceeds capacity; sticky until RST

## Operation
- Stream format: 16-bit word count N, high byte first, then N words, each high byte first.
- States: LEN_HI, LEN_LO, W_HI, W_LO, WRITE, DONE, ERR.
- A byte is accepted on a rising CLK edge with in_valid && in_ready. in_ready = 1 exactly in LEN_HI, LEN_LO, W_HI, W_LO.
- LEN_HI -> LEN_LO on accept. Latch count[15:8].
- LEN_LO on accept, with N = {count[15:8], byte}:
  - N == 0 -> DONE, no writes.
  - N > 2**ADDR_W -> ERR.
  - Otherwise -> W_HI with word index idx = 0.
- W_HI -> W_LO on accept. Latch wdata[15:8].
- W_LO -> WRITE on accept. Latch wdata[7:0].
- WRITE lasts one cycle: imem_we = 1, imem_addr = idx, imem_wdata = assembled word.
  - idx == N-1 -> DONE.
  - Otherwise idx += 1 -> W_HI.
- DONE: cpu_rst = 0, done = 1.
  - reload = 1 -> LEN_HI; cpu_rst returns to 1 on that same edge.
  - reload is ignored in all other states.
- ERR: cpu_rst = 1, err = 1, in_ready = 0. Exit only via RST.
- idx is ADDR_W+1 bits internally so that N = 2**ADDR_W is legal. imem_addr is idx[ADDR_W-1:0]; it never wraps within a load.
- Back-to-back bytes are legal. Gaps (in_valid low) stall the FSM in its current state with no side effects.

## Timing
- Reset values (async, immediate on RST rising):
  - state = LEN_HI, so in_ready = 1
  - cpu_rst = 1, done = 0, err = 0
  - imem_we = 0, imem_addr = 0, imem_wdata = 0, idx = 0
- All outputs except in_ready are registered. in_ready is decoded from state.
- Minimum cost is 3 cycles per word: 2 accepts + 1 WRITE. in_ready is low during the WRITE cycle.
- imem_we is high only in WRITE and never for two consecutive cycles.
- On the final word, DONE is entered on the edge that ends WRITE. cpu_rst falls and done rises on that edge, so the CPU's first fetch can never precede the last write.
- RST mid-load aborts immediately. Memory already written is not cleared. The next load restarts at LEN_HI, and err is cleared.
- in_data is ignored when in_ready = 0, even if in_valid = 1.

## Test plan
- After RST, stream 00 01 AB CD -> one imem_we pulse with addr 0, data 0xABCD; cpu_rst 1->0 and done 0->1 on the same edge; in_ready = 0 afterward.
- Stream N=3 with words 1234, 5678, 9ABC, back-to-back -> writes to addr 0,1,2 in order, each WRITE 3 cycles apart; 9 cycles from the first word byte to done.
- Stream 00 00 -> done = 1 two cycles after the first header byte; no imem_we pulse ever.
- ADDR_W = 4, stream 00 11 (N = 17) -> err = 1 and in_ready = 0 persist, further bytes are ignored, cpu_rst stays 1. Repeat with N = 16 -> 16 writes to addr 0..15, then done.
- In DONE, pulse reload, then stream 00 01 FF FF -> cpu_rst reasserted on the reload edge, addr 0 rewritten with 0xFFFF, done again. A reload pulse during W_LO has no effect.
- Assert RST after the high byte of word 2 of an N=4 load, then stream 00 01 00 07 -> outputs return to reset values asynchronously; next load writes addr 0 = 0x0007, then done.
